mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/gba_io_pkg.sv | 22 ++
 rtl/mem_arb_timer.sv | 35 +++
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_io_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gba_io_pkg
// Brief    : Shared transfer-width encodings and arbiter state type
// Revision : 1.0
// ============================================================================
package gba_io_pkg;

    localparam logic [1:0] DATA_WIDTH_0  = 2'b00;
    localparam logic [1:0] DATA_WIDTH_8  = 2'b01;
    localparam logic [1:0] DATA_WIDTH_16 = 2'b10;
    localparam logic [1:0] DATA_WIDTH_32 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_WR_DONE = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_timer
// Brief    : Read-return watchdog; expires on the RD_TIMEOUT-th counted cycle
// Revision : 1.0
// ============================================================================
module mem_arb_timer #(
    parameter int RD_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_expire = i_count && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && !o_expire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Cart/USB memory arbiter with starvation guard and read timeout
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import gba_io_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int RD_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cart_req,
    input  logic        cart_we,
    input  logic [25:0] cart_addr,
    input  logic [1:0]  cart_width,
    input  logic [31:0] cart_wdata,
    output logic        cart_ack,
    output logic [31:0] cart_rdata,
    input  logic        usb_req,
    input  logic        usb_we,
    input  logic [25:0] usb_addr,
    input  logic [31:0] usb_wdata,
    output logic        usb_ack,
    output logic [31:0] usb_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [25:0] mem_addr,
    output logic [1:0]  mem_width,
    output logic [31:0] mem_wdata,
    input  logic        mem_rd_ready,
    input  logic        mem_wr_ready,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        grant_usb,
    output logic        timeout_err
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    arb_state_t      r_state, w_state;
    logic [SC_W-1:0] r_starve, w_starve;
    logic            r_we, w_we;
    logic            w_grant_usb, w_mem_rd, w_mem_wr, w_cart_ack, w_usb_ack, w_timeout;
    logic [25:0]     w_mem_addr;
    logic [1:0]      w_mem_width;
    logic [31:0]     w_mem_wdata, w_cart_rdata, w_usb_rdata, w_rdata;
    logic            w_fin, w_fin_rd;
    logic            w_tmr_load, w_tmr_count, w_tmr_expire;

    // Timer controls come straight from state and inputs so expire never loops back through the FSM.
    assign w_tmr_load  = (r_state == ST_ISSUE) && !r_we && mem_rd_ready;
    assign w_tmr_count = (r_state == ST_WAIT_RD) && !mem_rd_valid;

    mem_arb_timer #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_tmr_load),
        .i_count  (w_tmr_count),
        .o_expire (w_tmr_expire)
    );

    always_comb begin
        w_state      = r_state;
        w_starve     = r_starve;
        w_we         = r_we;
        w_grant_usb  = grant_usb;
        w_mem_addr   = mem_addr;
        w_mem_width  = mem_width;
        w_mem_wdata  = mem_wdata;
        w_cart_rdata = cart_rdata;
        w_usb_rdata  = usb_rdata;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_cart_ack   = 1'b0;
        w_usb_ack    = 1'b0;
        w_timeout    = 1'b0;
        w_fin        = 1'b0;
        w_fin_rd     = 1'b0;
        w_rdata      = '0;

        case (r_state)
            ST_IDLE: begin
                if (!usb_req) begin
                    w_starve = '0;
                end
                // The ack cycle is skipped so a request held through ack is not granted twice.
                if (!(cart_ack || usb_ack)) begin
                    if (usb_req && (!cart_req || r_starve == STARVE_MAX)) begin
                        w_grant_usb = 1'b1;
                        w_mem_addr  = usb_addr;
                        w_mem_width = DATA_WIDTH_32;
                        w_mem_wdata = usb_wdata;
                        w_we        = usb_we;
                        w_starve    = '0;
                        w_state     = ST_ISSUE;
                    end else if (cart_req) begin
                        w_grant_usb = 1'b0;
                        w_mem_addr  = cart_addr;
                        w_mem_width = cart_width;
                        w_mem_wdata = cart_wdata;
                        w_we        = cart_we;
                        if (usb_req && r_starve != STARVE_MAX) begin
                            w_starve = r_starve + SC_W'(1);
                        end
                        w_state     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (r_we && mem_wr_ready) begin
                    w_mem_wr = 1'b1;
                    w_state  = ST_WR_DONE;
                end else if (!r_we && mem_rd_ready) begin
                    w_mem_rd = 1'b1;
                    w_state  = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (mem_rd_valid) begin
                    w_fin    = 1'b1;
                    w_fin_rd = 1'b1;
                    w_rdata  = mem_rd_data;
                    w_state  = ST_IDLE;
                end else if (w_tmr_expire) begin
                    w_fin     = 1'b1;
                    w_fin_rd  = 1'b1;
                    w_rdata   = '1;
                    w_timeout = 1'b1;
                    w_state   = ST_IDLE;
                end
            end
            ST_WR_DONE: begin
                w_fin   = 1'b1;
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (w_fin) begin
            if (grant_usb) begin
                w_usb_ack = 1'b1;
                if (w_fin_rd) begin
                    w_usb_rdata = w_rdata;
                end
            end else begin
                w_cart_ack = 1'b1;
                if (w_fin_rd) begin
                    w_cart_rdata = w_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_starve    <= '0;
            r_we        <= 1'b0;
            grant_usb   <= 1'b0;
            mem_addr    <= '0;
            mem_width   <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            cart_ack    <= 1'b0;
            cart_rdata  <= '0;
            usb_ack     <= 1'b0;
            usb_rdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_starve    <= w_starve;
            r_we        <= w_we;
            grant_usb   <= w_grant_usb;
            mem_addr    <= w_mem_addr;
            mem_width   <= w_mem_width;
            mem_wdata   <= w_mem_wdata;
            mem_rd      <= w_mem_rd;
            mem_wr      <= w_mem_wr;
            cart_ack    <= w_cart_ack;
            cart_rdata  <= w_cart_rdata;
            usb_ack     <= w_usb_ack;
            usb_rdata   <= w_usb_rdata;
            timeout_err <= w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with transaction-level model
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
    import gba_io_pkg::*;

    localparam int STARVE_LIMIT = 8;
    localparam int RD_TIMEOUT   = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cart_req, cart_we, usb_req, usb_we;
    logic [25:0] cart_addr, usb_addr;
    logic [1:0]  cart_width;
    logic [31:0] cart_wdata, usb_wdata;
    logic        cart_ack, usb_ack;
    logic [31:0] cart_rdata, usb_rdata;
    logic        mem_rd, mem_wr;
    logic [25:0] mem_addr;
    logic [1:0]  mem_width;
    logic [31:0] mem_wdata;
    logic        mem_rd_ready, mem_wr_ready, mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        grant_usb, timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .RD_TIMEOUT   (RD_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cart_req     (cart_req),
        .cart_we      (cart_we),
        .cart_addr    (cart_addr),
        .cart_width   (cart_width),
        .cart_wdata   (cart_wdata),
        .cart_ack     (cart_ack),
        .cart_rdata   (cart_rdata),
        .usb_req      (usb_req),
        .usb_we       (usb_we),
        .usb_addr     (usb_addr),
        .usb_wdata    (usb_wdata),
        .usb_ack      (usb_ack),
        .usb_rdata    (usb_rdata),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_width    (mem_width),
        .mem_wdata    (mem_wdata),
        .mem_rd_ready (mem_rd_ready),
        .mem_wr_ready (mem_wr_ready),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .grant_usb    (grant_usb),
        .timeout_err  (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: predicts next-cycle outputs from current inputs
    // ------------------------------------------------------------------
    logic        e_grant_usb, e_mem_rd, e_mem_wr, e_cart_ack, e_usb_ack, e_timeout;
    logic [25:0] e_mem_addr;
    logic [1:0]  e_mem_width;
    logic [31:0] e_mem_wdata, e_cart_rdata, e_usb_rdata;
    bit          m_busy, m_we, m_issued;
    int          m_wait, m_starve;

    task automatic model_reset();
        {e_grant_usb, e_mem_rd, e_mem_wr, e_cart_ack, e_usb_ack, e_timeout} = '0;
        e_mem_addr   = '0;
        e_mem_width  = '0;
        e_mem_wdata  = '0;
        e_cart_rdata = '0;
        e_usb_rdata  = '0;
        m_busy       = 1'b0;
        m_we         = 1'b0;
        m_issued     = 1'b0;
        m_wait       = 0;
        m_starve     = 0;
    endtask

    task automatic model_step();
        logic        ack_now, fin, fin_rd;
        logic [31:0] rd;
        ack_now = e_cart_ack | e_usb_ack;
        {e_mem_rd, e_mem_wr, e_cart_ack, e_usb_ack, e_timeout} = '0;
        fin    = 1'b0;
        fin_rd = 1'b0;
        rd     = '0;
        if (!m_busy) begin
            if (!usb_req) m_starve = 0;
            if (!ack_now && (usb_req || cart_req)) begin
                m_busy   = 1'b1;
                m_issued = 1'b0;
                if (usb_req && (!cart_req || m_starve == STARVE_LIMIT)) begin
                    e_grant_usb = 1'b1;
                    e_mem_addr  = usb_addr;
                    e_mem_width = DATA_WIDTH_32;
                    e_mem_wdata = usb_wdata;
                    m_we        = usb_we;
                    m_starve    = 0;
                end else begin
                    e_grant_usb = 1'b0;
                    e_mem_addr  = cart_addr;
                    e_mem_width = cart_width;
                    e_mem_wdata = cart_wdata;
                    m_we        = cart_we;
                    if (usb_req && m_starve < STARVE_LIMIT) m_starve++;
                end
            end
        end else if (!m_issued) begin
            if (m_we ? mem_wr_ready : mem_rd_ready) begin
                m_issued = 1'b1;
                m_wait   = 0;
                if (m_we) e_mem_wr = 1'b1;
                else      e_mem_rd = 1'b1;
            end
        end else if (m_we) begin
            fin = 1'b1;
        end else if (mem_rd_valid) begin
            fin    = 1'b1;
            fin_rd = 1'b1;
            rd     = mem_rd_data;
        end else begin
            m_wait++;
            if (m_wait == RD_TIMEOUT) begin
                fin       = 1'b1;
                fin_rd    = 1'b1;
                rd        = 32'hFFFF_FFFF;
                e_timeout = 1'b1;
            end
        end
        if (fin) begin
            m_busy = 1'b0;
            if (e_grant_usb) begin
                e_usb_ack = 1'b1;
                if (fin_rd) e_usb_rdata = rd;
            end else begin
                e_cart_ack = 1'b1;
                if (fin_rd) e_cart_rdata = rd;
            end
        end
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        chk("cycle_outputs",
            {grant_usb, mem_rd, mem_wr, mem_addr, mem_width, mem_wdata, cart_ack, usb_ack, timeout_err},
            {e_grant_usb, e_mem_rd, e_mem_wr, e_mem_addr, e_mem_width, e_mem_wdata, e_cart_ack, e_usb_ack, e_timeout});
        if (e_cart_ack) chk("cart_rdata", 66'(cart_rdata), 66'(e_cart_rdata));
        if (e_usb_ack)  chk("usb_rdata", 66'(usb_rdata), 66'(e_usb_rdata));
        if (rst_n) model_step();
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed cycle expectations
    // ------------------------------------------------------------------
    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          n_rd, rd_cyc, n_wr, wr_cyc, n_ack, ack_cyc, n_to, to_cyc, n_seq;
    logic [1:0]  wr_w;
    logic [31:0] wr_d, ack_d;
    logic [25:0] g_addr;
    logic [17:0] seq;

    initial begin
        rst_n = 1'b0;
        {cart_req, cart_we, usb_req, usb_we, mem_rd_ready, mem_wr_ready, mem_rd_valid} = '0;
        cart_addr = '0; usb_addr = '0; cart_width = DATA_WIDTH_0;
        cart_wdata = '0; usb_wdata = '0; mem_rd_data = '0;
        go(3);
        @(negedge clk);
        chk("reset_state",
            {grant_usb, mem_rd, mem_wr, mem_addr, mem_width, mem_wdata, cart_ack, usb_ack, timeout_err,
             |cart_rdata, |usb_rdata}, '0);

        // Cart read right after reset release; data returned in cycle 3
        n_rd = 0; rd_cyc = -1; n_ack = 0; ack_cyc = -1; ack_d = '0; g_addr = '0;
        for (int c = 0; c < 10; c++) begin
            go(1);
            if (c == 0) begin
                rst_n        = 1'b1;
                cart_we      = 1'b0;
                cart_addr    = 26'h0000100;
                cart_width   = DATA_WIDTH_32;
                mem_rd_ready = 1'b1;
            end
            cart_req     = (c <= 4);
            mem_rd_valid = (c == 3);
            mem_rd_data  = (c == 3) ? 32'h1234ABCD : 32'h0;
            @(negedge clk);
            if (c == 1) g_addr = mem_addr;
            if (mem_rd) begin n_rd++; rd_cyc = c; end
            if (cart_ack) begin n_ack++; ack_cyc = c; ack_d = cart_rdata; end
        end
        chk("A_grant_addr", 66'(g_addr), 66'(26'h0000100));
        chk("A_rd_count", 66'(n_rd), 66'(1));
        chk("A_rd_cycle", 66'(rd_cyc), 66'(2));
        chk("A_ack_count", 66'(n_ack), 66'(1));
        chk("A_ack_cycle", 66'(ack_cyc), 66'(4));
        chk("A_rdata", 66'(ack_d), 66'(32'h1234ABCD));

        // USB write with write-ready held low for five cycles
        usb_we = 1'b1; usb_addr = 26'h2A5A5A4; usb_wdata = 32'hDEADBEEF;
        n_wr = 0; wr_cyc = -1; n_ack = 0; ack_cyc = -1; wr_w = '0; wr_d = '0;
        for (int c = 0; c < 10; c++) begin
            go(1);
            usb_req      = (c <= 7);
            mem_wr_ready = (c >= 5);
            mem_rd_valid = (c == 2);
            @(negedge clk);
            if (mem_wr) begin n_wr++; wr_cyc = c; wr_w = mem_width; wr_d = mem_wdata; end
            if (usb_ack) begin n_ack++; ack_cyc = c; end
        end
        mem_rd_valid = 1'b0;
        chk("B_wr_count", 66'(n_wr), 66'(1));
        chk("B_wr_cycle", 66'(wr_cyc), 66'(6));
        chk("B_wr_width", 66'(wr_w), 66'(2'b11));
        chk("B_wr_data", 66'(wr_d), 66'(32'hDEADBEEF));
        chk("B_ack_cycle", 66'(ack_cyc), 66'(7));

        // Both requesters held high: 8 cart grants then 1 usb grant
        cart_we = 1'b1; cart_addr = 26'h10; cart_wdata = 32'h0000C0DE; cart_width = DATA_WIDTH_8;
        usb_we = 1'b1; usb_addr = 26'h20; usb_wdata = 32'h5555AAAA;
        mem_wr_ready = 1'b1;
        n_seq = 0; seq = '0;
        for (int c = 0; c < 80; c++) begin
            go(1);
            cart_req = 1'b1;
            usb_req  = 1'b1;
            @(negedge clk);
            if (mem_wr) begin
                if (n_seq < 18) seq[n_seq] = grant_usb;
                n_seq++;
            end
        end
        go(1);
        cart_req = 1'b0;
        usb_req  = 1'b0;
        go(8);
        chk("C_grant_count", 66'(n_seq), 66'(20));
        chk("C_grant_seq", 66'(seq), 66'(18'h20100));

        // Cart read that never receives data
        cart_we = 1'b0; cart_addr = 26'h0ABCDEF; cart_width = DATA_WIDTH_16;
        n_to = 0; to_cyc = -1; n_ack = 0; ack_cyc = -1; ack_d = '0;
        for (int c = 0; c < 262; c++) begin
            go(1);
            cart_req = (c <= 257);
            @(negedge clk);
            if (timeout_err) begin n_to++; to_cyc = c; end
            if (cart_ack) begin n_ack++; ack_cyc = c; ack_d = cart_rdata; end
        end
        chk("D_timeout_count", 66'(n_to), 66'(1));
        chk("D_timeout_cycle", 66'(to_cyc), 66'(257));
        chk("D_ack_cycle", 66'(ack_cyc), 66'(257));
        chk("D_rdata", 66'(ack_d), 66'(32'hFFFF_FFFF));

        // Reset while mem_rd is asserted, then a normal cart read
        cart_addr = 26'h3FFFFFF; cart_width = DATA_WIDTH_16;
        go(1);
        cart_req = 1'b1;
        go(2);
        @(negedge clk);
        chk("E_pre_reset_rd", 66'(mem_rd), 66'(1));
        #2;
        rst_n    = 1'b0;
        cart_req = 1'b0;
        #1;
        chk("E_async_reset",
            {grant_usb, mem_rd, mem_wr, mem_addr, mem_width, mem_wdata, cart_ack, usb_ack, timeout_err,
             |cart_rdata, |usb_rdata}, '0);
        go(2);
        n_ack = 0; ack_cyc = -1; ack_d = '0; g_addr = '0; wr_w = '0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) go(1);
            if (c == 0) rst_n = 1'b1;
            cart_req     = (c <= 4);
            mem_rd_valid = (c == 3);
            mem_rd_data  = (c == 3) ? 32'hCAFEF00D : 32'h0;
            @(negedge clk);
            if (c == 1) begin g_addr = mem_addr; wr_w = mem_width; end
            if (cart_ack) begin n_ack++; ack_cyc = c; ack_d = cart_rdata; end
        end
        chk("E_grant_addr", 66'({g_addr, wr_w}), 66'({26'h3FFFFFF, 2'b10}));
        chk("E_ack_cycle", 66'(ack_cyc), 66'(4));
        chk("E_rdata", 66'(ack_d), 66'(32'hCAFEF00D));

        go(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
